// File: rtl/scope_capture_ctrl_if.sv
// Sample-stream and VGA read-side signals shared by the ADC feeder, the renderer
// and the scope capture controller.
interface scope_capture_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          sampleValid;
    logic [DW-1:0] sampleData;
    logic          vgaVsync;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    logic          frameReady;

    modport master (
        output sampleValid, sampleData, vgaVsync, rdAddr,
        input  rdData, frameReady
    );
    modport slave (
        input  sampleValid, sampleData, vgaVsync, rdAddr,
        output rdData, frameReady
    );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Triggered capture into a double-buffered frame memory with pre-trigger history;
// the display bank flips only at vertical sync so the renderer never sees a torn frame.
module scope_capture_ctrl #(
    parameter int DEPTH   = 640,
    parameter int AW      = 10,
    parameter int DW      = 8,
    parameter int PRETRIG = 64,
    parameter int AUTO_TO = 1023
) (
    input  logic                Clk,
    input  logic                capRst,
    input  logic [DW-1:0]       trigLevel,
    input  logic                trigSlope,
    input  logic [1:0]          trigMode,
    input  logic                arm,
    output logic                triggered,
    output logic [2:0]          capState,
    scope_capture_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int            CW          = $clog2(AUTO_TO + 1);
    localparam logic [AW:0]   DEPTH_X     = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PRE_A       = AW'(PRETRIG);
    localparam logic [AW-1:0] PRE_LAST    = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] POST_LAST   = AW'(DEPTH - PRETRIG - 2);
    localparam logic [AW-1:0] PTR_LAST    = AW'(DEPTH - 1);
    localparam logic [CW-1:0] AUTO_LAST   = CW'(AUTO_TO - 1);
    localparam logic [1:0]    MODE_AUTO   = 2'b00;
    localparam logic [1:0]    MODE_SINGLE = 2'b10;

    // Operands are always < DEPTH, so one conditional correction suffices.
    function automatic logic [AW-1:0] modAdd(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= DEPTH_X) begin
            s = s - DEPTH_X;
        end
        return s[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] modSub(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            s = s + DEPTH_X;
        end
        return s[AW-1:0];
    endfunction

    state_t        state;
    logic          front;
    logic [AW-1:0] frontStart;
    logic [AW-1:0] backStart;
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] wrPtrNext;
    logic [AW-1:0] fillCnt;
    logic [AW-1:0] postCnt;
    logic [CW-1:0] autoCnt;
    logic [1:0]    modeR;
    logic [DW-1:0] prev;
    logic          prevValid;
    logic          wrEn;
    logic          levelHit;
    logic          autoHit;
    logic          rdInRange;
    logic [AW-1:0] rdIdx;
    logic [DW-1:0] bank0 [DEPTH];
    logic [DW-1:0] bank1 [DEPTH];

    assign capState = state;

    // Write enable, trigger detection and read address folding.
    always_comb begin
        wrEn      = 1'b0;
        levelHit  = 1'b0;
        autoHit   = 1'b0;
        wrPtrNext = (wrPtr == PTR_LAST) ? {AW{1'b0}} : wrPtr + AW'(1);
        if (bus.sampleValid && ((state == FILL) || (state == ARMED) || (state == POST))) begin
            wrEn = 1'b1;
        end else begin
            wrEn = 1'b0;
        end
        if (!prevValid) begin
            levelHit = 1'b0;
        end else if (!trigSlope) begin
            levelHit = (prev < trigLevel) && (bus.sampleData >= trigLevel);
        end else begin
            levelHit = (prev > trigLevel) && (bus.sampleData <= trigLevel);
        end
        if (modeR == MODE_AUTO) begin
            autoHit = (autoCnt == AUTO_LAST);
        end else begin
            autoHit = 1'b0;
        end
        rdInRange = ({1'b0, bus.rdAddr} < DEPTH_X);
        rdIdx     = modAdd(frontStart, bus.rdAddr);
    end

    // Sample writes always land in the back bank; contents survive reset.
    always_ff @(posedge Clk) begin
        if (wrEn && !capRst) begin
            if (front) begin
                bank0[wrPtr] <= bus.sampleData;
            end else begin
                bank1[wrPtr] <= bus.sampleData;
            end
        end
    end

    // Display read port: front bank only, one-cycle latency.
    always_ff @(posedge Clk) begin
        if (capRst) begin
            bus.rdData <= {DW{1'b0}};
        end else if (!rdInRange) begin
            bus.rdData <= {DW{1'b0}};
        end else if (front) begin
            bus.rdData <= bank1[rdIdx];
        end else begin
            bus.rdData <= bank0[rdIdx];
        end
    end

    // Capture sequencer with registered status outputs.
    always_ff @(posedge Clk) begin
        if (capRst) begin
            state          <= IDLE;
            modeR          <= MODE_AUTO;
            front          <= 1'b0;
            frontStart     <= {AW{1'b0}};
            backStart      <= {AW{1'b0}};
            wrPtr          <= {AW{1'b0}};
            fillCnt        <= {AW{1'b0}};
            postCnt        <= {AW{1'b0}};
            autoCnt        <= {CW{1'b0}};
            prev           <= {DW{1'b0}};
            prevValid      <= 1'b0;
            triggered      <= 1'b0;
            bus.frameReady <= 1'b0;
        end else begin
            bus.frameReady <= 1'b0;
            if (wrEn) begin
                wrPtr     <= wrPtrNext;
                prev      <= bus.sampleData;
                prevValid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    modeR   <= trigMode;
                    fillCnt <= {AW{1'b0}};
                    if ((trigMode != MODE_SINGLE) || arm) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (bus.sampleValid) begin
                        if (fillCnt == PRE_LAST) begin
                            state   <= ARMED;
                            autoCnt <= {CW{1'b0}};
                        end else begin
                            fillCnt <= fillCnt + AW'(1);
                        end
                    end
                end
                ARMED: begin
                    if (bus.sampleValid) begin
                        if (modeR == MODE_AUTO) begin
                            autoCnt <= autoCnt + CW'(1);
                        end
                        if (levelHit || autoHit) begin
                            backStart <= modSub(wrPtr, PRE_A);
                            postCnt   <= {AW{1'b0}};
                            triggered <= 1'b1;
                            state     <= POST;
                        end
                    end
                end
                POST: begin
                    if (bus.sampleValid) begin
                        if (postCnt == POST_LAST) begin
                            triggered <= 1'b0;
                            state     <= DONE;
                        end else begin
                            postCnt <= postCnt + AW'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.vgaVsync) begin
                        front          <= ~front;
                        frontStart     <= backStart;
                        bus.frameReady <= 1'b1;
                        wrPtr          <= {AW{1'b0}};
                        prevValid      <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl: scenario tasks plus a read-back
// scoreboard fed from a bench-side model of both frame banks.
module tb_scope_capture_ctrl;
    localparam int DEPTH   = 640;
    localparam int PRETRIG = 64;

    logic       Clk = 1'b0;
    logic       capRst;
    logic [7:0] trigLevel;
    logic       trigSlope;
    logic [1:0] trigMode;
    logic       arm;
    logic       triggered;
    logic [2:0] capState;

    always #5 Clk = ~Clk;

    scope_capture_ctrl_if #(.AW(10), .DW(8)) bus ();

    scope_capture_ctrl dut (
        .Clk       (Clk),
        .capRst    (capRst),
        .trigLevel (trigLevel),
        .trigSlope (trigSlope),
        .trigMode  (trigMode),
        .arm       (arm),
        .triggered (triggered),
        .capState  (capState),
        .bus       (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mBank [0:1][0:DEPTH-1];
    int         mFront;
    int         mStart;
    int         mPtr;
    int         mTrig;
    bit         mActive;
    logic [7:0] expQ [$];

    function automatic logic [7:0] ramp(input int i);
        return 8'((2 * i) % 256);
    endfunction

    function automatic logic [7:0] modelRead(input int c);
        if (c >= DEPTH) return 8'd0;
        return mBank[mFront][(mStart + c) % DEPTH];
    endfunction

    task automatic sendSample(input logic [7:0] v, input int gap);
        @(posedge Clk); #1;
        bus.sampleValid = 1'b1;
        bus.sampleData  = v;
        if (mActive) begin
            mBank[1 - mFront][mPtr] = v;
            mPtr = (mPtr + 1) % DEPTH;
        end
        @(posedge Clk); #1;
        bus.sampleValid = 1'b0;
        repeat (gap) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic pulseVsync();
        @(posedge Clk); #1;
        bus.vgaVsync = 1'b1;
        @(posedge Clk); #1;
        bus.vgaVsync = 1'b0;
    endtask

    task automatic pulseArm();
        @(posedge Clk); #1;
        arm = 1'b1;
        @(posedge Clk); #1;
        arm = 1'b0;
    endtask

    task automatic modelSwap();
        mFront = 1 - mFront;
        mStart = (mTrig - PRETRIG + DEPTH) % DEPTH;
        mPtr   = 0;
    endtask

    task automatic doReset(input logic [1:0] mode);
        @(posedge Clk); #1;
        trigMode = mode;
        capRst   = 1'b1;
        @(posedge Clk);
        @(posedge Clk); #1;
        capRst  = 1'b0;
        mFront  = 0;
        mStart  = 0;
        mPtr    = 0;
        mActive = (mode != 2'b10);
    endtask

    task automatic test_reset();
        trigMode = 2'b00;
        @(posedge Clk); #1;
        capRst = 1'b1;
        bus.sampleValid = 1'b1;
        bus.sampleData  = 8'd55;
        @(posedge Clk); #1;
        bus.sampleValid = 1'b0;
        @(posedge Clk); #1;
        checks++; if (capState !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", capState); end
        checks++; if (bus.rdData !== 8'd0) begin errors++; $display("FAIL reset_rdData: got %0d expected 0", bus.rdData); end
        checks++; if (bus.frameReady !== 1'b0) begin errors++; $display("FAIL reset_frameReady: got %0b expected 0", bus.frameReady); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered: got %0b expected 0", triggered); end
        capRst = 1'b0;
        @(posedge Clk); #1;
        checks++; if (capState !== 3'd1) begin errors++; $display("FAIL reset_release_fill: got %0d expected 1", capState); end
    endtask

    task automatic test_normal_rising();
        int         cols [4];
        logic [7:0] exps [4];
        logic [7:0] e;
        bit         early;
        trigLevel = 8'd128;
        trigSlope = 1'b0;
        doReset(2'b01);
        for (int i = 0; i < PRETRIG; i++) sendSample(ramp(i), 2);
        checks++; if (capState !== 3'd2) begin errors++; $display("FAIL rise_armed: got %0d expected 2", capState); end
        mTrig = mPtr;
        sendSample(ramp(64), 2);
        checks++; if (capState !== 3'd3) begin errors++; $display("FAIL rise_post: got %0d expected 3", capState); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rise_triggered: got %0b expected 1", triggered); end
        for (int i = 65; i < 639; i++) sendSample(ramp(i), 2);
        checks++; if (capState !== 3'd3) begin errors++; $display("FAIL rise_post_hold: got %0d expected 3", capState); end
        sendSample(ramp(639), 2);
        checks++; if (capState !== 3'd4) begin errors++; $display("FAIL rise_done: got %0d expected 4", capState); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rise_trig_clear: got %0b expected 0", triggered); end
        early = 1'b0;
        repeat (10) begin @(negedge Clk); if (bus.frameReady !== 1'b0) early = 1'b1; end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL rise_no_swap_before_vsync: got %0b expected 0", early); end
        pulseVsync();
        modelSwap();
        checks++; if (bus.frameReady !== 1'b1) begin errors++; $display("FAIL rise_frameReady: got %0b expected 1", bus.frameReady); end
        checks++; if (capState !== 3'd0) begin errors++; $display("FAIL rise_idle: got %0d expected 0", capState); end
        @(posedge Clk); #1;
        checks++; if (bus.frameReady !== 1'b0) begin errors++; $display("FAIL rise_frameReady_pulse: got %0b expected 0", bus.frameReady); end
        cols = '{64, 0, 63, 100};
        exps = '{8'd128, 8'd0, 8'd126, modelRead(100)};
        for (int k = 0; k < 4; k++) begin
            @(posedge Clk); #1;
            bus.rdAddr = 10'(cols[k]);
            expQ.push_back(exps[k]);
            @(posedge Clk);
            @(negedge Clk);
            e = expQ.pop_front();
            checks++; if (bus.rdData !== e) begin errors++; $display("FAIL rise_read col %0d: got %0d expected %0d", cols[k], bus.rdData, e); end
        end
    endtask

    task automatic test_falling_equal();
        int         cols [3];
        logic [7:0] exps [3];
        logic [7:0] e;
        trigLevel = 8'd99;
        trigSlope = 1'b1;
        doReset(2'b01);
        for (int i = 0; i < PRETRIG; i++) sendSample(8'd100, 0);
        sendSample(8'd100, 0);
        checks++; if (capState !== 3'd2) begin errors++; $display("FAIL fall_no_trig_eq1: got %0d expected 2", capState); end
        sendSample(8'd100, 0);
        checks++; if (capState !== 3'd2) begin errors++; $display("FAIL fall_no_trig_eq2: got %0d expected 2", capState); end
        mTrig = mPtr;
        sendSample(8'd99, 0);
        checks++; if (capState !== 3'd3) begin errors++; $display("FAIL fall_trig: got %0d expected 3", capState); end
        for (int i = 0; i < 575; i++) sendSample(8'd0, 0);
        checks++; if (capState !== 3'd4) begin errors++; $display("FAIL fall_done: got %0d expected 4", capState); end
        pulseVsync();
        modelSwap();
        checks++; if (bus.frameReady !== 1'b1) begin errors++; $display("FAIL fall_frameReady: got %0b expected 1", bus.frameReady); end
        cols = '{64, 63, 65};
        exps = '{8'd99, 8'd100, 8'd0};
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            bus.rdAddr = 10'(cols[k]);
            expQ.push_back(exps[k]);
            @(posedge Clk);
            @(negedge Clk);
            e = expQ.pop_front();
            checks++; if (bus.rdData !== e) begin errors++; $display("FAIL fall_read col %0d: got %0d expected %0d", cols[k], bus.rdData, e); end
        end
    endtask

    task automatic test_auto_timeout();
        int         cols [3];
        logic [7:0] e;
        bit         early;
        trigLevel = 8'd200;
        trigSlope = 1'b0;
        doReset(2'b00);
        for (int i = 0; i < PRETRIG; i++) sendSample(8'd50, 0);
        for (int i = 0; i < 1022; i++) sendSample(8'd50, 0);
        checks++; if (capState !== 3'd2) begin errors++; $display("FAIL auto_still_armed: got %0d expected 2", capState); end
        mTrig = mPtr;
        sendSample(8'd50, 0);
        checks++; if (capState !== 3'd3) begin errors++; $display("FAIL auto_forced: got %0d expected 3", capState); end
        for (int i = 0; i < 575; i++) sendSample(8'd50, 0);
        checks++; if (capState !== 3'd4) begin errors++; $display("FAIL auto_done: got %0d expected 4", capState); end
        early = 1'b0;
        repeat (20) begin @(negedge Clk); if (bus.frameReady !== 1'b0) early = 1'b1; end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL auto_no_swap_before_vsync: got %0b expected 0", early); end
        pulseVsync();
        modelSwap();
        checks++; if (bus.frameReady !== 1'b1) begin errors++; $display("FAIL auto_frameReady: got %0b expected 1", bus.frameReady); end
        cols = '{0, 320, 639};
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            bus.rdAddr = 10'(cols[k]);
            expQ.push_back(8'd50);
            @(posedge Clk);
            @(negedge Clk);
            e = expQ.pop_front();
            checks++; if (bus.rdData !== e) begin errors++; $display("FAIL auto_read col %0d: got %0d expected %0d", cols[k], bus.rdData, e); end
        end
    endtask

    task automatic test_single();
        logic [7:0] e;
        bit         leftIdle;
        bit         sawReady;
        trigLevel = 8'd128;
        trigSlope = 1'b0;
        doReset(2'b10);
        for (int i = 0; i < 10; i++) sendSample(8'd7, 0);
        checks++; if (capState !== 3'd0) begin errors++; $display("FAIL single_wait_arm: got %0d expected 0", capState); end
        pulseArm();
        mActive = 1'b1;
        checks++; if (capState !== 3'd1) begin errors++; $display("FAIL single_arm_fill: got %0d expected 1", capState); end
        for (int i = 0; i < PRETRIG; i++) sendSample(ramp(i), 0);
        mTrig = mPtr;
        sendSample(ramp(64), 0);
        for (int i = 65; i < 365; i++) sendSample(ramp(i), 0);
        pulseArm();
        checks++; if (capState !== 3'd3) begin errors++; $display("FAIL single_arm_in_post: got %0d expected 3", capState); end
        for (int i = 365; i < 640; i++) sendSample(ramp(i), 0);
        checks++; if (capState !== 3'd4) begin errors++; $display("FAIL single_done: got %0d expected 4", capState); end
        pulseVsync();
        modelSwap();
        mActive = 1'b0;
        checks++; if (bus.frameReady !== 1'b1) begin errors++; $display("FAIL single_frameReady: got %0b expected 1", bus.frameReady); end
        leftIdle = 1'b0;
        sawReady = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            sendSample(8'(i), 0);
            if (capState !== 3'd0) leftIdle = 1'b1;
            if ((i % 100) == 99) begin
                pulseVsync();
                if (bus.frameReady !== 1'b0) sawReady = 1'b1;
            end
        end
        checks++; if (leftIdle !== 1'b0) begin errors++; $display("FAIL single_no_rearm: got %0b expected 0", leftIdle); end
        checks++; if (sawReady !== 1'b0) begin errors++; $display("FAIL single_no_frameReady: got %0b expected 0", sawReady); end
        pulseArm();
        mActive = 1'b1;
        checks++; if (capState !== 3'd1) begin errors++; $display("FAIL single_rearm_fill: got %0d expected 1", capState); end
        for (int i = 0; i < PRETRIG; i++) sendSample(ramp(i), 0);
        mTrig = mPtr;
        for (int i = 64; i < 640; i++) sendSample(ramp(i), 0);
        pulseVsync();
        modelSwap();
        mActive = 1'b0;
        checks++; if (bus.frameReady !== 1'b1) begin errors++; $display("FAIL single_second_frame: got %0b expected 1", bus.frameReady); end
        @(posedge Clk); #1;
        bus.rdAddr = 10'd64;
        expQ.push_back(8'd128);
        @(posedge Clk);
        @(negedge Clk);
        e = expQ.pop_front();
        checks++; if (bus.rdData !== e) begin errors++; $display("FAIL single_read col 64: got %0d expected %0d", bus.rdData, e); end
    endtask

    task automatic test_wrap_tearing();
        int         cols [6];
        logic [7:0] exps [6];
        logic [7:0] e;
        bit         early;
        trigLevel = 8'd128;
        trigSlope = 1'b0;
        doReset(2'b01);
        for (int k = 0; k < 650; k++) sendSample(8'((k % DEPTH) % 100), 0);
        checks++; if (capState !== 3'd2) begin errors++; $display("FAIL wrap_armed: got %0d expected 2", capState); end
        mTrig = mPtr;
        sendSample(8'd200, 0);
        checks++; if (capState !== 3'd3) begin errors++; $display("FAIL wrap_trig_at_10: got %0d expected 3", capState); end
        for (int a = 11; a < 586; a++) sendSample(8'(a % 100), 0);
        checks++; if (capState !== 3'd4) begin errors++; $display("FAIL wrap_done: got %0d expected 4", capState); end
        early = 1'b0;
        for (int r = 0; r < 10; r++) begin
            repeat (498) begin @(negedge Clk); if (bus.frameReady !== 1'b0) early = 1'b1; end
            @(posedge Clk); #1;
            bus.rdAddr = 10'(64 + r);
            expQ.push_back(modelRead(64 + r));
            @(posedge Clk);
            @(negedge Clk);
            e = expQ.pop_front();
            checks++; if (bus.rdData !== e) begin errors++; $display("FAIL tear_old_frame col %0d: got %0d expected %0d", 64 + r, bus.rdData, e); end
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL tear_no_early_swap: got %0b expected 0", early); end
        pulseVsync();
        modelSwap();
        checks++; if (bus.frameReady !== 1'b1) begin errors++; $display("FAIL wrap_frameReady: got %0b expected 1", bus.frameReady); end
        cols = '{53, 54, 63, 64, 700, 639};
        exps = '{8'd39, 8'd0, 8'd9, 8'd200, 8'd0, modelRead(639)};
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk); #1;
            bus.rdAddr = 10'(cols[k]);
            expQ.push_back(exps[k]);
            @(posedge Clk);
            @(negedge Clk);
            e = expQ.pop_front();
            checks++; if (bus.rdData !== e) begin errors++; $display("FAIL wrap_read col %0d: got %0d expected %0d", cols[k], bus.rdData, e); end
        end
    endtask

    initial begin
        capRst          = 1'b1;
        trigLevel       = 8'd0;
        trigSlope       = 1'b0;
        trigMode        = 2'b00;
        arm             = 1'b0;
        bus.sampleValid = 1'b0;
        bus.sampleData  = 8'd0;
        bus.vgaVsync    = 1'b0;
        bus.rdAddr      = 10'd0;
        mFront          = 0;
        mStart          = 0;
        mPtr            = 0;
        mTrig           = 0;
        mActive         = 1'b0;
        test_reset();
        test_normal_rising();
        test_falling_equal();
        test_auto_timeout();
        test_single();
        test_wrap_tearing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
